// File: rtl/nn_pkg.sv
`default_nettype none
// nn_pkg: Q4.12 constants, stage payload types and PLAN sigmoid helpers.
// Rev 1.0
package nn_pkg;

  localparam int unsigned ONE  = 4096;
  localparam int unsigned HALF = 2048;
  localparam int unsigned C1   = 2560;
  localparam int unsigned C2   = 3456;
  localparam int unsigned BRK1 = 4096;
  localparam int unsigned BRK2 = 9728;
  localparam int unsigned BRK3 = 20480;

  typedef logic [16:0] q4_12_t;
  typedef logic [1:0]  seg_t;
  typedef logic [12:0] y_t;

  localparam seg_t SEG_LIN0 = 2'd0;
  localparam seg_t SEG_LIN1 = 2'd1;
  localparam seg_t SEG_LIN2 = 2'd2;
  localparam seg_t SEG_SAT  = 2'd3;

  // Segments 0..2 only occur for |x| < 20480, so 15 bits of magnitude suffice downstream.
  typedef struct packed {
    logic        sign;
    logic [14:0] ax;
    seg_t        seg;
  } s1_t;

  typedef struct packed {
    logic sign;
    y_t   y;
  } s2_t;

  function automatic q4_12_t abs_q(input q4_12_t x);
    return x[16] ? (~x + q4_12_t'(1)) : x;
  endfunction

  function automatic seg_t plan_seg(input q4_12_t ax);
    if (ax < q4_12_t'(BRK1))      return SEG_LIN0;
    else if (ax < q4_12_t'(BRK2)) return SEG_LIN1;
    else if (ax < q4_12_t'(BRK3)) return SEG_LIN2;
    else                          return SEG_SAT;
  endfunction

  function automatic y_t plan_y(input logic [14:0] ax, input seg_t seg);
    y_t y;
    case (seg)
      SEG_LIN0: y = y_t'(ax >> 2) + y_t'(HALF);
      SEG_LIN1: y = y_t'(ax >> 3) + y_t'(C1);
      SEG_LIN2: y = y_t'(ax >> 5) + y_t'(C2);
      default:  y = y_t'(ONE);
    endcase
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_pipe_reg.sv
`default_nettype none
// nn_pipe_reg: one-entry valid/data pipeline register with load enable.
// Rev 1.0
module nn_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_act_sigmoid.sv
`default_nettype none
// nn_act_sigmoid: 3-stage piecewise-linear sigmoid on a Q4.12 neuron sum.
// Rev 1.0
module nn_act_sigmoid
  import nn_pkg::*;
#(
  parameter int FRAC_BITS = 12,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16:0]          out_data,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam q4_12_t Q_ONE = q4_12_t'(1 << FRAC_BITS);

  logic   stall;
  logic   adv;
  q4_12_t ax;
  s1_t    s1_d, s1_q;
  s2_t    s2_d, s2_q;
  q4_12_t s3_d;
  logic   s1_valid, s2_valid;

  // A single global stall freezes every stage, so bubbles keep their slots.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  always_comb begin
    ax        = abs_q(in_data);
    s1_d.sign = in_data[16];
    s1_d.ax   = ax[14:0];
    s1_d.seg  = plan_seg(ax);
  end

  nn_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .in_valid (in_valid),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_data (s1_q)
  );

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.y    = plan_y(s1_q.ax, s1_q.seg);
  end

  nn_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .in_valid (s1_valid),
    .in_data  (s2_d),
    .out_valid(s2_valid),
    .out_data (s2_q)
  );

  always_comb begin
    s3_d = s2_q.sign ? (Q_ONE - q4_12_t'(s2_q.y)) : q4_12_t'(s2_q.y);
  end

  nn_pipe_reg #(.W(17)) u_s3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .in_valid (s2_valid),
    .in_data  (s3_d),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  // Counted on the stage 1 -> 2 move so a stalled sample is counted exactly once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (adv && s1_valid && (s1_q.seg == SEG_SAT) && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_act_sigmoid.sv
`default_nettype none
// tb_nn_act_sigmoid: directed-table and random scoreboard bench for nn_act_sigmoid.
// Rev 1.0
module tb_nn_act_sigmoid;

  typedef struct packed {
    logic [16:0] din;
    logic [16:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [15:0] sat_cnt;

  int          tests = 0;
  int          fails = 0;
  int          n_in  = 0;
  int          n_out = 0;
  logic [16:0] exp_q[$];
  logic        rand_done = 1'b0;
  vec_t        vecs[9];

  always #5 clk = ~clk;

  nn_act_sigmoid #(.FRAC_BITS(12), .SAT_CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sat_cnt  (sat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] plan_ref(input logic [16:0] d);
    int x, ax, y;
    x  = int'($signed(d));
    ax = (x < 0) ? -x : x;
    if (ax < 4096)       y = ax / 4 + 2048;
    else if (ax < 9728)  y = ax / 8 + 2560;
    else if (ax < 20480) y = ax / 32 + 3456;
    else                 y = 4096;
    return 17'((x < 0) ? (4096 - y) : y);
  endfunction

  // Output monitor: transfers are decided on the next rising edge, sampled here mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d, required no output", out_data);
      end else begin
        check($sformatf("out_data#%0d", n_out), {15'd0, out_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [16:0] d, input logic [16:0] e);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(e);
        n_in++;
        break;
      end
      w++;
      if (w >= 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready got 0, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      tick();
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out;

    vecs[0] = '{17'd0,          17'd2048};
    vecs[1] = '{17'd4096,       17'd3072};
    vecs[2] = '{17'(-4096),     17'd1024};
    vecs[3] = '{17'd8192,       17'd3584};
    vecs[4] = '{17'd9728,       17'd3760};
    vecs[5] = '{17'd20480,      17'd4096};
    vecs[6] = '{17'd65535,      17'd4096};
    vecs[7] = '{17'h10000,      17'd0};
    vecs[8] = '{17'(-20480),    17'd0};

    // Reset held with a saturating input pending.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 17'd20480;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_sat_cnt", {16'd0, sat_cnt}, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("in_ready_after_rst", {31'd0, in_ready}, 1);
    check("rst_out_data", {15'd0, out_data}, 0);

    // Latency of a lone sample on an idle pipe.
    send(vecs[0].din, vecs[0].exp);
    check("lat_c1_valid", {31'd0, out_valid}, 0);
    tick();
    check("lat_c2_valid", {31'd0, out_valid}, 0);
    tick();
    check("lat_c3_valid", {31'd0, out_valid}, 1);
    check("lat_c3_data", {15'd0, out_data}, 2048);
    drain();

    // Back-to-back stream, then extremes.
    for (int i = 0; i < 6; i++) send(vecs[i].din, vecs[i].exp);
    drain();
    for (int i = 6; i < 9; i++) send(vecs[i].din, vecs[i].exp);
    drain();
    check("sat_cnt_after_extremes", {16'd0, sat_cnt}, 4);

    // Backpressure: three samples fill the pipe, the fourth waits.
    base_out  = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i].din, vecs[i].exp);
    in_valid = 1'b1;
    in_data  = vecs[3].din;
    check("bp_in_ready", {31'd0, in_ready}, 0);
    check("bp_out_valid", {31'd0, out_valid}, 1);
    check("bp_out_data", {15'd0, out_data}, 2048);
    repeat (3) begin
      tick();
      check("bp_hold_data", {15'd0, out_data}, 2048);
      check("bp_hold_in_ready", {31'd0, in_ready}, 0);
    end
    check("bp_nothing_emitted", n_out - base_out, 0);
    out_ready = 1'b1;
    send(vecs[3].din, vecs[3].exp);
    drain();
    check("bp_emitted_count", n_out - base_out, 4);

    // Reset with two saturating samples in flight.
    base_out = n_out;
    send(17'd20480, 17'd4096);
    send(17'd65535, 17'd4096);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    check("midrst_sat_cnt", {16'd0, sat_cnt}, 0);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    repeat (6) tick();
    check("midrst_no_output", n_out - base_out, 0);
    check("midrst_sat_cnt_late", {16'd0, sat_cnt}, 0);

    // Random traffic against the reference model.
    base_in  = n_in;
    base_out = n_out;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      logic [16:0] d;
      int          gap;
      gap = int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       d = 17'($urandom);
        1:       d = 17'($urandom_range(0, 24000));
        2:       d = 17'(-int'($urandom_range(0, 24000)));
        default: d = vecs[$urandom_range(0, 8)].din;
      endcase
      repeat (gap) tick();
      send(d, plan_ref(d));
    end
    rand_done = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    drain();
    check("rand_in_count", n_in - base_in, 1000);
    check("rand_out_eq_in", n_out - base_out, n_in - base_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
